// File: rtl/pipe_stall_flush_seq_if.sv
// pipe_stall_flush_seq_if: hazard inputs and per-stage pipeline control strobes of the stall/flush sequencer
interface pipe_stall_flush_seq_if #(
    parameter int CNT_W = 16
);
    logic             i_stall_req;
    logic             i_mispredict;
    logic             o_pc_write;
    logic             o_pc_redirect;
    logic             o_ifid_write;
    logic             o_ifid_flush;
    logic             o_idex_bubble;
    logic [1:0]       o_seq_state;
    logic             o_stall_timeout;
    logic [CNT_W-1:0] o_stall_cnt;
    logic [CNT_W-1:0] o_flush_cnt;

    modport master (
        output i_stall_req, i_mispredict,
        input  o_pc_write, o_pc_redirect, o_ifid_write, o_ifid_flush, o_idex_bubble,
        input  o_seq_state, o_stall_timeout, o_stall_cnt, o_flush_cnt
    );

    modport slave (
        input  i_stall_req, i_mispredict,
        output o_pc_write, o_pc_redirect, o_ifid_write, o_ifid_flush, o_idex_bubble,
        output o_seq_state, o_stall_timeout, o_stall_cnt, o_flush_cnt
    );
endinterface

// File: rtl/pipe_stall_flush_seq.sv
// pipe_stall_flush_seq: Mealy stall/flush sequencer with post-reset drain window and stall watchdog.
// Optional perf counters (stall_cnt, flush_cnt) are built only when PIPE_PERF_CNT_EN is defined.
module pipe_stall_flush_seq #(
    parameter int DRAIN_CYCLES = 2,
    parameter int MAX_STALL    = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pipe_stall_flush_seq_if.slave bus
);
    localparam int DW = $clog2(DRAIN_CYCLES + 1);
    localparam int RW = $clog2(MAX_STALL + 1);

    typedef enum logic [1:0] {
        S_DRAIN = 2'd0,
        S_RUN   = 2'd1,
        S_STALL = 2'd2,
        S_FLUSH = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [DW-1:0]   r_drain_cnt;
    logic [RW-1:0]   r_run_cnt;
    logic [RW-1:0]   w_run_nxt;
    logic            r_timeout;
    logic            w_active;
    logic            w_mp;
    logic            w_st;

    // Hazards are only honoured in RUN/STALL; DRAIN and FLUSH ignore both inputs.
    assign w_active = (r_state == S_RUN) || (r_state == S_STALL);
    assign w_mp     = w_active & bus.i_mispredict;
    assign w_st     = w_active & ~bus.i_mispredict & bus.i_stall_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_DRAIN;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_DRAIN: w_next = (r_drain_cnt == DW'(DRAIN_CYCLES - 1)) ? S_RUN : S_DRAIN;
            S_FLUSH: w_next = S_RUN;
            default: w_next = w_mp ? S_FLUSH : (w_st ? S_STALL : S_RUN);
        endcase
    end

    always_comb begin
        bus.o_pc_write    = (r_state != S_DRAIN) & ~w_st;
        bus.o_pc_redirect = w_mp;
        bus.o_ifid_write  = (r_state == S_FLUSH) | (w_active & ~w_st & ~w_mp);
        bus.o_ifid_flush  = (r_state == S_DRAIN) | w_mp;
        bus.o_idex_bubble = (r_state == S_DRAIN) | w_mp | w_st;
        bus.o_seq_state   = r_state;
    end

    assign w_run_nxt = (w_next != S_STALL) ? '0 :
                       (r_run_cnt == RW'(MAX_STALL)) ? r_run_cnt : r_run_cnt + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drain_cnt <= '0;
            r_run_cnt   <= '0;
            r_timeout   <= 1'b0;
        end else begin
            r_drain_cnt <= (r_state == S_DRAIN) ? r_drain_cnt + 1'b1 : '0;
            r_run_cnt   <= w_run_nxt;
            r_timeout   <= r_timeout | (w_run_nxt == RW'(MAX_STALL));
        end
    end

    assign bus.o_stall_timeout = r_timeout;

`ifdef PIPE_PERF_CNT_EN
    localparam int CW = $bits(bus.o_stall_cnt);

    logic [CW-1:0] r_stall_cnt;
    logic [CW-1:0] r_flush_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (r_state == S_STALL && r_stall_cnt != '1)
                r_stall_cnt <= r_stall_cnt + 1'b1;
            if (w_mp && r_flush_cnt != '1)
                r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

    assign bus.o_stall_cnt = r_stall_cnt;
    assign bus.o_flush_cnt = r_flush_cnt;
`else
    assign bus.o_stall_cnt = '0;
    assign bus.o_flush_cnt = '0;
`endif
endmodule

// File: tb/tb_pipe_stall_flush_seq.sv
// tb_pipe_stall_flush_seq: directed scenarios plus random hazards against a behavioural pipeline-control model
module tb_pipe_stall_flush_seq;
    localparam int DC = 2;
    localparam int MS = 15;
`ifdef PIPE_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    bit   run_chk = 1'b0;

    pipe_stall_flush_seq_if #(.CNT_W(16)) bus ();

    pipe_stall_flush_seq #(.DRAIN_CYCLES(DC), .MAX_STALL(MS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Model: cycles of drain left, whether this cycle is the flush slot, whether stalled.
    int m_drain = DC;
    bit m_flush = 1'b0;
    bit m_stall = 1'b0;
    int m_run   = 0;
    bit m_to    = 1'b0;
    int m_scnt  = 0;
    int m_fcnt  = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_drain <= DC;
            m_flush <= 1'b0;
            m_stall <= 1'b0;
            m_run   <= 0;
            m_to    <= 1'b0;
            m_scnt  <= 0;
            m_fcnt  <= 0;
        end else if (m_drain > 0) begin
            m_drain <= m_drain - 1;
        end else if (m_flush) begin
            m_flush <= 1'b0;
            m_run   <= 0;
        end else begin
            automatic bit ns = bus.i_mispredict ? 1'b0 : bus.i_stall_req;
            automatic int nr = ns ? ((m_run + 1 > MS) ? MS : m_run + 1) : 0;
            if (m_stall && m_scnt < 65535) m_scnt <= m_scnt + 1;
            if (bus.i_mispredict && m_fcnt < 65535) m_fcnt <= m_fcnt + 1;
            m_flush <= bus.i_mispredict;
            m_stall <= ns;
            m_run   <= nr;
            if (nr == MS) m_to <= 1'b1;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (run_chk) begin
            automatic bit drain  = m_drain > 0;
            automatic bit active = !drain && !m_flush;
            automatic bit amp    = active && bus.i_mispredict;
            automatic bit ast    = active && !bus.i_mispredict && bus.i_stall_req;
            automatic int st     = drain ? 0 : m_flush ? 3 : m_stall ? 2 : 1;
            chk("seq_state", bus.o_seq_state, st);
            chk("pc_write", bus.o_pc_write, int'(!drain && !ast));
            chk("pc_redirect", bus.o_pc_redirect, int'(amp));
            if (!amp) chk("ifid_write", bus.o_ifid_write, int'(!drain && !ast));
            chk("ifid_flush", bus.o_ifid_flush, int'(drain || amp));
            chk("idex_bubble", bus.o_idex_bubble, int'(drain || amp || ast));
            chk("stall_timeout", bus.o_stall_timeout, int'(m_to));
            chk("stall_cnt", bus.o_stall_cnt, PERF ? m_scnt : 0);
            chk("flush_cnt", bus.o_flush_cnt, PERF ? m_fcnt : 0);
        end
    end

    task automatic step(input bit sr, input bit mp);
        @(posedge clk);
        #1;
        bus.i_stall_req  = sr;
        bus.i_mispredict = mp;
    endtask

    initial begin
        bus.i_stall_req  = 1'b0;
        bus.i_mispredict = 1'b0;
        run_chk = 1'b1;
        repeat (2) step(1'b0, 1'b0);
        // T1: drain window, inputs ignored
        rst_n = 1'b1;
        bus.i_stall_req  = 1'b1;
        bus.i_mispredict = 1'b1;
        #1;
        chk("t1_state_d0", bus.o_seq_state, 0);
        chk("t1_pcw_d0", bus.o_pc_write, 0);
        chk("t1_flush_d0", bus.o_ifid_flush, 1);
        step(1'b0, 1'b0);
        #1;
        chk("t1_state_d1", bus.o_seq_state, 0);
        chk("t1_pcw_d1", bus.o_pc_write, 0);
        step(1'b0, 1'b0);
        #1;
        chk("t1_state_run", bus.o_seq_state, 1);
        chk("t1_pcw_run", bus.o_pc_write, 1);
        // T2: three-cycle stall
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0);
            #1;
            chk("t2_pcw", bus.o_pc_write, 0);
            chk("t2_ifidw", bus.o_ifid_write, 0);
            chk("t2_bubble", bus.o_idex_bubble, 1);
        end
        step(1'b0, 1'b0);
        #1;
        chk("t2_release_state", bus.o_seq_state, 2);
        chk("t2_release_pcw", bus.o_pc_write, 1);
        step(1'b0, 1'b0);
        #1;
        chk("t2_state", bus.o_seq_state, 1);
        chk("t2_stall_cnt", bus.o_stall_cnt, PERF ? 3 : 0);
        chk("t2_flush_cnt", bus.o_flush_cnt, 0);
        // T3: mispredict beats stall, FLUSH ignores held stall_req
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        #1;
        chk("t3_redirect", bus.o_pc_redirect, 1);
        chk("t3_ifid_flush", bus.o_ifid_flush, 1);
        step(1'b1, 1'b0);
        #1;
        chk("t3_flush_state", bus.o_seq_state, 3);
        chk("t3_flush_pcw", bus.o_pc_write, 1);
        chk("t3_flush_bubble", bus.o_idex_bubble, 0);
        step(1'b1, 1'b0);
        #1;
        chk("t3_after_state", bus.o_seq_state, 1);
        chk("t3_after_pcw", bus.o_pc_write, 0);
        chk("t3_flush_cnt", bus.o_flush_cnt, PERF ? 1 : 0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        // T4: watchdog after the 15th stalled edge, sticky afterwards
        for (int i = 1; i <= 20; i++) begin
            step(1'b1, 1'b0);
            #1;
            if (i == 15) chk("t4_timeout_pre", bus.o_stall_timeout, 0);
            if (i == 16) chk("t4_timeout_set", bus.o_stall_timeout, 1);
        end
        chk("t4_still_stalling", bus.o_pc_write, 0);
        repeat (3) step(1'b0, 1'b0);
        #1;
        chk("t4_timeout_sticky", bus.o_stall_timeout, 1);
        // T5: async reset in the middle of FLUSH
        step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        #1;
        chk("t5_in_flush", bus.o_seq_state, 3);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t5_state", bus.o_seq_state, 0);
        chk("t5_pcw", bus.o_pc_write, 0);
        chk("t5_ifid_flush", bus.o_ifid_flush, 1);
        chk("t5_bubble", bus.o_idex_bubble, 1);
        chk("t5_timeout", bus.o_stall_timeout, 0);
        chk("t5_flush_cnt", bus.o_flush_cnt, 0);
        step(1'b0, 1'b0);
        rst_n = 1'b1;
        // Random hazards with occasional stall bursts and resets
        for (int i = 0; i < 1500; i++) begin
            automatic bit sr = ($urandom_range(0, 99) < 45);
            automatic bit mp = ($urandom_range(0, 99) < 10);
            if ($urandom_range(0, 199) == 0) begin
                step(sr, mp);
                rst_n = 1'b0;
                step(sr, mp);
                rst_n = 1'b1;
            end else if ($urandom_range(0, 99) == 0) begin
                repeat ($urandom_range(10, 25)) step(1'b1, 1'b0);
            end else begin
                step(sr, mp);
            end
        end
        step(1'b0, 1'b0);
        @(posedge clk);
        #1;
        run_chk = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
